// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO drain scheduler and its sibling schedulers.
// Holds the scheduler state encoding, the index/counter width helpers and the output flag encodings.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_BURST = 2'd2
    } sched_state_t;

    localparam logic ABORT_PULSE = 1'b1;
    localparam logic LAST_MARK   = 1'b1;

    // Channel index width; a single-channel scheduler still needs one bit.
    function automatic int src_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
// Shared by the accelerator's schedulers.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);
    localparam logic [IDX_W:0] NUM_CH_EXT = (IDX_W + 1)'(NUM_CH);

    logic [IDX_W-1:0] w_cand [NUM_CH];
    logic [NUM_CH-1:0] w_req_at;
    logic [NUM_CH:0]   w_seen;
    logic [IDX_W-1:0]  w_idx_chain [NUM_CH+1];

    assign w_seen[0]      = 1'b0;
    assign w_idx_chain[0] = '0;

    // Candidate gi is offset gi+1 from the last grant; wrap by compare so non-power-of-two counts work.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
        logic [IDX_W:0] w_sum;
        assign w_sum       = {1'b0, i_last} + (IDX_W + 1)'(gi + 1);
        assign w_cand[gi]  = (w_sum >= NUM_CH_EXT) ? IDX_W'(w_sum - NUM_CH_EXT) : IDX_W'(w_sum);
        assign w_req_at[gi] = i_req[w_cand[gi]];
        assign w_seen[gi+1] = w_seen[gi] | w_req_at[gi];
        assign w_idx_chain[gi+1] = (!w_seen[gi] && w_req_at[gi]) ? w_cand[gi] : w_idx_chain[gi];
    end

    assign o_hit = w_seen[NUM_CH];
    assign o_idx = w_idx_chain[NUM_CH];

endmodule

// File: rtl/fifo_drain_scheduler.sv
// Drains NUM_CH show-ahead FIFOs round-robin in atomic bursts into one registered valid/ready stream.
// A burst whose FIFO stays empty for STALL_MAX cycles is aborted without an out_last.
module fifo_drain_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 8,
    parameter int STALL_MAX  = 64,
    localparam int SRC_W     = src_width(NUM_CH)
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic                         en,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [NUM_CH-1:0]            fifo_pre_fill,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rd_data,
    output logic [NUM_CH-1:0]            fifo_rd_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SRC_W-1:0]             out_src,
    output logic                         out_last,
    output logic                         busy,
    output logic                         burst_abort
);
    localparam int CNT_W   = count_width(BURST_LEN);
    localparam int STALL_W = count_width(STALL_MAX);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BURST_LEN - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
    localparam logic [SRC_W-1:0]   GRANT_INIT = SRC_W'(NUM_CH - 1);

    sched_state_t          r_state, w_state_next;
    logic [NUM_CH-1:0]     r_primed;
    logic [SRC_W-1:0]      r_last_grant, w_last_grant_next;
    logic [SRC_W-1:0]      r_grant, w_grant_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [STALL_W-1:0]    r_stall_cnt, w_stall_next;
    logic                  r_out_valid, w_out_valid_next;
    logic [DATA_WIDTH-1:0] r_out_data, w_out_data_next;
    logic [SRC_W-1:0]      r_out_src, w_out_src_next;
    logic                  r_out_last, w_out_last_next;
    logic                  r_abort, w_abort_next;

    logic [DATA_WIDTH-1:0] w_ch_data [NUM_CH];
    logic [NUM_CH-1:0]     w_eligible;
    logic                  w_hit;
    logic [SRC_W-1:0]      w_pick;
    logic                  w_pop;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_ch_data[gi]  = fifo_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign fifo_rd_en[gi] = w_pop && (r_grant == SRC_W'(gi));
    end

    assign w_eligible = r_primed & ch_mask & ~fifo_empty;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (SRC_W)
    ) u_rr_pick (
        .i_req  (w_eligible),
        .i_last (r_last_grant),
        .o_hit  (w_hit),
        .o_idx  (w_pick)
    );

    // Pops only when the output stage is free or being consumed this cycle.
    assign w_pop = (r_state == ST_BURST) && !fifo_empty[r_grant] && (!r_out_valid || out_ready);

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_grant_next      = r_grant;
        w_cnt_next        = r_cnt;
        w_stall_next      = r_stall_cnt;
        w_abort_next      = 1'b0;
        w_out_valid_next  = r_out_valid && !out_ready;
        w_out_data_next   = r_out_data;
        w_out_src_next    = r_out_src;
        w_out_last_next   = r_out_last;

        case (r_state)
            ST_IDLE: begin
                if (en) w_state_next = ST_ARB;
            end
            ST_ARB: begin
                if (!en) begin
                    w_state_next = ST_IDLE;
                end else if (w_hit) begin
                    w_grant_next = w_pick;
                    w_cnt_next   = '0;
                    w_stall_next = '0;
                    w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_pop) begin
                    w_out_valid_next = 1'b1;
                    w_out_data_next  = w_ch_data[r_grant];
                    w_out_src_next   = r_grant;
                    w_out_last_next  = (r_cnt == CNT_LAST) ? LAST_MARK : ~LAST_MARK;
                    w_cnt_next       = r_cnt + CNT_W'(1);
                    w_stall_next     = '0;
                    if (r_cnt == CNT_LAST) begin
                        w_last_grant_next = r_grant;
                        w_state_next      = ST_ARB;
                    end
                end else if (fifo_empty[r_grant]) begin
                    if (r_stall_cnt == STALL_LAST) begin
                        w_abort_next      = ABORT_PULSE;
                        w_last_grant_next = r_grant;
                        w_state_next      = ST_ARB;
                    end else begin
                        w_stall_next = r_stall_cnt + STALL_W'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state      <= ST_IDLE;
            r_primed     <= '0;
            r_last_grant <= GRANT_INIT;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_stall_cnt  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= '0;
            r_out_last   <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_primed     <= r_primed | fifo_pre_fill;
            r_last_grant <= w_last_grant_next;
            r_grant      <= w_grant_next;
            r_cnt        <= w_cnt_next;
            r_stall_cnt  <= w_stall_next;
            r_out_valid  <= w_out_valid_next;
            r_out_data   <= w_out_data_next;
            r_out_src    <= w_out_src_next;
            r_out_last   <= w_out_last_next;
            r_abort      <= w_abort_next;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_src     = r_out_src;
    assign out_last    = r_out_last;
    assign busy        = (r_state == ST_BURST);
    assign burst_abort = r_abort;

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Scoreboard bench for fifo_drain_scheduler: a queue-based show-ahead FIFO model per channel,
// directed scenarios pushing expected words, and a negedge monitor comparing every presented word.
module tb_fifo_drain_scheduler;
    localparam int NCH = 4;
    localparam int DW  = 8;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic            rd_clk = 1'b0;
    logic            rd_rst = 1'b1;
    logic            en = 1'b0;
    logic            out_ready = 1'b1;
    logic [NCH-1:0]  ch_mask = '0;
    logic [NCH-1:0]  fifo_pre_fill = '0;
    logic [NCH-1:0]  fifo_empty = '1;
    logic [NCH*DW-1:0] fifo_rd_data = '0;
    logic [NCH-1:0]  fifo_rd_en;
    logic            out_valid, out_last, busy, burst_abort;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   mon_idx = 0;
    logic mon_enable = 1'b1;

    logic [DW-1:0] fq [NCH][$];
    int fill_seq [NCH] = '{default: 0};
    int cyc = 0, pop_total = 0, first_pop = -1, last_pop = -1;
    int onehot_err = 0, hold_pop_err = 0, abort_cnt = 0;

    fifo_drain_scheduler #(
        .NUM_CH     (NCH),
        .DATA_WIDTH (DW),
        .BURST_LEN  (8),
        .STALL_MAX  (4)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .en            (en),
        .ch_mask       (ch_mask),
        .fifo_pre_fill (fifo_pre_fill),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_last      (out_last),
        .busy          (busy),
        .burst_abort   (burst_abort)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic load(input int ch, input int n);
        logic [1:0] c2;
        logic [5:0] s6;
        for (int k = 0; k < n; k++) begin
            c2 = 2'(ch);
            s6 = 6'(fill_seq[ch]);
            fq[ch].push_back({c2, s6});
            fill_seq[ch]++;
        end
    endtask

    task automatic expect_burst(input int ch, input int start, input int n, input logic complete);
        exp_t e;
        logic [5:0] s6;
        for (int k = 0; k < n; k++) begin
            s6     = 6'(start + k);
            e.src  = 2'(ch);
            e.data = {2'(ch), s6};
            e.last = complete && (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_stats();
        pop_total = 0; first_pop = -1; last_pop = -1;
        onehot_err = 0; hold_pop_err = 0; abort_cnt = 0;
    endtask

    // One clock: sample strobes at the edge, then apply pops and refresh the show-ahead outputs.
    task automatic tick();
        logic [NCH-1:0] snap;
        logic held, ab;
        @(posedge rd_clk);
        snap = fifo_rd_en;
        held = out_valid && !out_ready;
        ab   = burst_abort;
        #1;
        cyc++;
        if (ab) abort_cnt++;
        if (snap != '0) begin
            pop_total++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if ($countones(snap) != 1) onehot_err++;
            if (held) hold_pop_err++;
        end
        for (int ch = 0; ch < NCH; ch++)
            if (snap[ch] && fq[ch].size() > 0) void'(fq[ch].pop_front());
        for (int ch = 0; ch < NCH; ch++) begin
            fifo_empty[ch] = (fq[ch].size() == 0);
            fifo_rd_data[ch*DW +: DW] = (fq[ch].size() > 0) ? fq[ch][0] : '0;
        end
    endtask

    task automatic run_drain(input string name, input int budget, input logic toggle);
        int n = 0;
        while (mon_idx < exp_q.size() && n < budget) begin
            tick();
            if (toggle) out_ready = ~out_ready;
            n++;
        end
        check({name, "_drained"}, mon_idx, exp_q.size());
        out_ready = 1'b1;
    endtask

    always @(negedge rd_clk) begin
        if (mon_enable && !rd_rst && out_valid) begin
            if (mon_idx >= exp_q.size()) begin
                if (out_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got src=%0d data=%h last=%0d required no word",
                             out_src, out_data, out_last);
                end
            end else begin
                checks++;
                if (out_src !== exp_q[mon_idx].src || out_data !== exp_q[mon_idx].data ||
                    out_last !== exp_q[mon_idx].last) begin
                    errors++;
                    $display("FAIL word%0d: got src=%0d data=%h last=%0d required src=%0d data=%h last=%0d",
                             mon_idx, out_src, out_data, out_last,
                             exp_q[mon_idx].src, exp_q[mon_idx].data, exp_q[mon_idx].last);
                end
                if (out_ready) mon_idx++;
            end
        end
    end

    initial begin
        int n;
        ch_mask = 4'hF;
        repeat (3) tick();
        check("rst_rd_en", int'(fifo_rd_en), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_src", int'(out_src), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_abort", int'(burst_abort), 0);
        rd_rst = 1'b0;
        tick();

        // Round-robin over all primed channels, 8-word bursts, 1-cycle ARB gap.
        load(0, 16); load(1, 8); load(2, 8); load(3, 8);
        tick(); fifo_pre_fill = 4'hF; tick(); fifo_pre_fill = 4'h0;
        expect_burst(0, 0, 8, 1); expect_burst(1, 0, 8, 1); expect_burst(2, 0, 8, 1);
        expect_burst(3, 0, 8, 1); expect_burst(0, 8, 8, 1);
        clear_stats(); en = 1'b1;
        run_drain("t1", 200, 1'b0);
        check("t1_pops", pop_total, 40);
        check("t1_span", last_pop - first_pop, 43);
        check("t1_onehot", onehot_err, 0);
        en = 1'b0; tick(); tick();
        check("t1_idle_busy", int'(busy), 0);

        // Only channel 2 prefilled (single-cycle pulse): only it is granted, twice.
        rd_rst = 1'b1; tick(); rd_rst = 1'b0; tick();
        load(0, 8); load(1, 8); load(3, 8); load(2, 16);
        tick(); fifo_pre_fill = 4'b0100; tick(); fifo_pre_fill = 4'h0;
        expect_burst(2, 8, 8, 1); expect_burst(2, 16, 8, 1);
        clear_stats(); en = 1'b1;
        run_drain("t2", 200, 1'b0);
        repeat (10) tick();
        check("t2_pops", pop_total, 16);
        check("t2_ch0_left", fq[0].size(), 8);
        check("t2_ch1_left", fq[1].size(), 8);
        check("t2_ch3_left", fq[3].size(), 8);
        en = 1'b0; tick(); tick();

        // out_ready toggling every cycle: no pop while held, words stay intact.
        fifo_pre_fill = 4'hF; tick(); fifo_pre_fill = 4'h0;
        expect_burst(3, 8, 8, 1); expect_burst(0, 16, 8, 1); expect_burst(1, 8, 8, 1);
        clear_stats(); en = 1'b1;
        run_drain("t3", 400, 1'b1);
        check("t3_pop_while_held", hold_pop_err, 0);
        check("t3_pops", pop_total, 24);
        en = 1'b0; tick(); tick();

        // Channel 1 runs dry after 3 words: abort after 4 empty cycles, then channel 2.
        rd_rst = 1'b1; tick(); rd_rst = 1'b0; tick();
        fifo_pre_fill = 4'hF; tick(); fifo_pre_fill = 4'h0;
        load(1, 3); load(2, 8); tick();
        expect_burst(1, 16, 3, 0); expect_burst(2, 24, 8, 1);
        clear_stats(); en = 1'b1;
        run_drain("t4", 200, 1'b0);
        check("t4_abort_pulses", abort_cnt, 1);
        check("t4_span", last_pop - first_pop, 15);
        check("t4_pops", pop_total, 11);
        en = 1'b0; tick(); tick();

        // en dropped after the 5th word: burst completes, then idle.
        load(3, 8); load(0, 8); tick();
        expect_burst(3, 16, 8, 1);
        clear_stats(); en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (en && pop_total >= 5) en = 1'b0;
        end
        check("t5_pops", pop_total, 8);
        check("t5_busy", int'(busy), 0);
        check("t5_ch0_left", fq[0].size(), 8);
        check("t5_drained", mon_idx, exp_q.size());

        // Reset mid-burst: outputs clear at once, first grant afterwards is channel 0.
        mon_enable = 1'b0;
        clear_stats(); en = 1'b1;
        n = 0;
        while (pop_total < 3 && n < 50) begin
            tick();
            n++;
        end
        check("t6_reached_pops", pop_total, 3);
        rd_rst = 1'b1;
        #1;
        check("t6_rst_rd_en", int'(fifo_rd_en), 0);
        check("t6_rst_out_valid", int'(out_valid), 0);
        check("t6_rst_out_data", int'(out_data), 0);
        check("t6_rst_out_src", int'(out_src), 0);
        check("t6_rst_out_last", int'(out_last), 0);
        check("t6_rst_busy", int'(busy), 0);
        en = 1'b0;
        tick(); rd_rst = 1'b0;
        load(0, 3); load(1, 8);
        tick(); fifo_pre_fill = 4'hF; tick(); fifo_pre_fill = 4'h0;
        mon_enable = 1'b1;
        expect_burst(0, 27, 8, 1); expect_burst(1, 19, 8, 1);
        clear_stats(); en = 1'b1;
        run_drain("t6", 200, 1'b0);
        check("t6_pops", pop_total, 16);
        en = 1'b0; tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
